// File: rtl/im_display_sched_if.sv
// Button, classifier and display-select signals of the image/label display sequencer.
// slave is the sequencer's view; master is the surrounding logic (or a bench).
interface im_display_sched_if;
  logic       next_pulse;
  logic       last_pulse;
  logic       frame_end;
  logic       cnn_done;
  logic [1:0] cnn_class;
  logic       cnn_start;
  logic [1:0] cnn_img;
  logic [1:0] im_sel;
  logic [1:0] char_sel;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  next_pulse, last_pulse, frame_end, cnn_done, cnn_class,
    output cnn_start, cnn_img, im_sel, char_sel, busy, timeout_err
  );

  modport master (
    output next_pulse, last_pulse, frame_end, cnn_done, cnn_class,
    input  cnn_start, cnn_img, im_sel, char_sel, busy, timeout_err
  );
endinterface

// File: rtl/im_display_sched.sv
// Display sequencer: runs one classification per selected image and commits the image bank
// and the result label together on a frame boundary, so a label never lags its image.
module im_display_sched #(
  parameter int N_IM           = 3,
  parameter int TIMEOUT_CYCLES = 16777215
) (
  input logic               video_clk,
  input logic               rst,
  im_display_sched_if.slave bus
);
  localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST   = 2'(N_IM - 1);
  localparam logic [1:0]       CLASS_NONE = 2'd3;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ALIGN = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t           state_r;
  logic [1:0]       pending_r;
  logic [1:0]       result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cnn_start_r;
  logic [1:0]       cnn_img_r;
  logic [1:0]       im_sel_r;
  logic [1:0]       char_sel_r;
  logic             busy_r;
  logic             timeout_err_r;
  logic [1:0]       pend_next_s;
  logic [1:0]       pend_prev_s;

  // Wrap-around neighbours of the pending image index
  always_comb begin
    pend_next_s = 2'd0;
    pend_prev_s = IDX_LAST;
    if (pending_r == IDX_LAST) begin
      pend_next_s = 2'd0;
    end else begin
      pend_next_s = pending_r + 2'd1;
    end
    if (pending_r == 2'd0) begin
      pend_prev_s = IDX_LAST;
    end else begin
      pend_prev_s = pending_r - 2'd1;
    end
  end

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_BOOT;
      pending_r     <= 2'd0;
      result_r      <= CLASS_NONE;
      cnt_r         <= '0;
      cnn_start_r   <= 1'b0;
      cnn_img_r     <= 2'd0;
      im_sel_r      <= 2'd0;
      char_sel_r    <= CLASS_NONE;
      busy_r        <= 1'b1;
      timeout_err_r <= 1'b0;
    end else begin
      cnn_start_r <= 1'b0;
      case (state_r)
        S_BOOT: begin
          state_r     <= S_START;
          cnn_start_r <= 1'b1;
          cnn_img_r   <= pending_r;
        end
        S_START: begin
          state_r <= S_WAIT;
          cnt_r   <= '0;
        end
        S_WAIT: begin
          // A done on the terminal count still delivers its class
          if (bus.cnn_done) begin
            result_r <= bus.cnn_class;
            state_r  <= S_ALIGN;
          end else if (cnt_r == CNT_LAST) begin
            result_r      <= CLASS_NONE;
            timeout_err_r <= 1'b1;
            state_r       <= S_ALIGN;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          if (bus.frame_end) begin
            im_sel_r   <= pending_r;
            char_sel_r <= result_r;
            busy_r     <= 1'b0;
            state_r    <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (bus.next_pulse && !bus.last_pulse) begin
            pending_r   <= pend_next_s;
            cnn_img_r   <= pend_next_s;
            cnn_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_START;
          end else if (bus.last_pulse && !bus.next_pulse) begin
            pending_r   <= pend_prev_s;
            cnn_img_r   <= pend_prev_s;
            cnn_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_START;
          end
        end
        default: begin
          busy_r  <= 1'b1;
          state_r <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.cnn_start   = cnn_start_r;
  assign bus.cnn_img     = cnn_img_r;
  assign bus.im_sel      = im_sel_r;
  assign bus.char_sel    = char_sel_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_im_display_sched.sv
// Randomized bench for im_display_sched, checked against a transaction-level model of the
// selected index, committed image/label and sticky timeout flag.
module tb_im_display_sched;
  localparam int N_IM = 3;
  localparam int T    = 100;

  logic video_clk = 1'b0;
  logic rst;

  im_display_sched_if bus ();

  im_display_sched #(.N_IM(N_IM), .TIMEOUT_CYCLES(T)) dut (
    .video_clk (video_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 video_clk = ~video_clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_pend;
  int m_im;
  int m_char;
  int m_terr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.next_pulse = 1'b0;
    bus.last_pulse = 1'b0;
    bus.frame_end  = 1'b0;
    bus.cnn_done   = 1'b0;
    bus.cnn_class  = 2'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_im"},    bus.im_sel,      0);
    check_val({tag, "_char"},  bus.char_sel,    3);
    check_val({tag, "_img"},   bus.cnn_img,     0);
    check_val({tag, "_start"}, bus.cnn_start,   0);
    check_val({tag, "_busy"},  bus.busy,        1);
    check_val({tag, "_terr"},  bus.timeout_err, 0);
  endtask

  task automatic check_held(input string tag);
    check_val({tag, "_im"},    bus.im_sel,    m_im);
    check_val({tag, "_char"},  bus.char_sel,  m_char);
    check_val({tag, "_busy"},  bus.busy,      1);
    check_val({tag, "_start"}, bus.cnn_start, 0);
    check_val({tag, "_img"},   bus.cnn_img,   m_pend);
  endtask

  task automatic check_show(input string tag);
    check_val({tag, "_im"},    bus.im_sel,      m_im);
    check_val({tag, "_char"},  bus.char_sel,    m_char);
    check_val({tag, "_busy"},  bus.busy,        0);
    check_val({tag, "_start"}, bus.cnn_start,   0);
    check_val({tag, "_terr"},  bus.timeout_err, m_terr);
  endtask

  // Called right after the edge that raised cnn_start. done_at: edge index after WAIT entry
  // on which done is sampled (0 = never). fe_after: edges after ALIGN entry to the commit frame_end.
  task automatic wait_phase(input int done_at, input int cls, input int fe_after);
    int align_at;
    int commit_at;
    int res;
    align_at  = (done_at > 0) ? done_at : T;
    commit_at = align_at + fe_after;
    res       = (done_at > 0) ? cls : 3;
    bus.next_pulse = 1'($urandom_range(0, 1));
    tick();
    bus.next_pulse = 1'b0;
    check_held("wait_entry");
    for (int c = 1; c <= commit_at; c++) begin
      bus.cnn_done   = (c == done_at) || (c > align_at && $urandom_range(0, 3) == 0);
      bus.cnn_class  = (c == done_at) ? 2'(cls) : 2'($urandom_range(0, 3));
      bus.frame_end  = (c == commit_at) || (c == align_at) ||
                       (c < align_at && $urandom_range(0, 3) == 0);
      bus.next_pulse = ($urandom_range(0, 5) == 0);
      bus.last_pulse = ($urandom_range(0, 5) == 0);
      tick();
      if (c < commit_at) begin
        check_held("inflight");
      end else begin
        m_im   = m_pend;
        m_char = res;
        if (done_at == 0) m_terr = 1;
        check_show("commit");
      end
    end
    idle_inputs();
  endtask

  task automatic request(input int kind, input int done_at, input int cls, input int fe_after);
    bus.next_pulse = (kind == 0);
    bus.last_pulse = (kind == 1);
    m_pend = (kind == 0) ? (m_pend + 1) % N_IM : (m_pend + N_IM - 1) % N_IM;
    tick();
    bus.next_pulse = 1'b0;
    bus.last_pulse = 1'b0;
    check_val("req_start", bus.cnn_start, 1);
    check_val("req_img",   bus.cnn_img,   m_pend);
    check_val("req_busy",  bus.busy,      1);
    check_val("req_im",    bus.im_sel,    m_im);
    check_val("req_char",  bus.char_sel,  m_char);
    wait_phase(done_at, cls, fe_after);
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_im   = 0;
    m_char = 3;
    m_terr = 0;
  endtask

  task automatic show_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_end = 1'($urandom_range(0, 1));
      bus.cnn_done  = 1'($urandom_range(0, 1));
      bus.cnn_class = 2'($urandom_range(0, 3));
      tick();
      check_show("idle");
    end
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int sel;
    int done_at;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #13;
    check_reset_vals("in_reset");
    tick();
    rst = 1'b0;
    check_reset_vals("boot");
    tick();
    check_val("boot_start", bus.cnn_start, 1);
    check_val("boot_img",   bus.cnn_img,   0);
    check_val("boot_busy",  bus.busy,      1);
    wait_phase(10, 2, 50);

    // next x3 then last: cnn_img 1,2,0 then 2
    request(0, 7, 0, 3);
    request(0, 1, 1, 1);
    request(0, 20, 2, 5);
    request(1, 4, 0, 2);

    // timeout, then a successful run: flag stays set
    request(0, 0, 0, 1);
    request(1, 5, 1, 1);

    // both pulses together are ignored; done in SHOW has no effect
    bus.next_pulse = 1'b1;
    bus.last_pulse = 1'b1;
    tick();
    idle_inputs();
    check_show("both");
    bus.cnn_done  = 1'b1;
    bus.cnn_class = 2'd2;
    tick();
    idle_inputs();
    check_show("done_in_show");
    tick();
    check_show("done_in_show2");

    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 1);
      sel  = $urandom_range(0, 3);
      case (sel)
        0:       done_at = 0;
        1:       done_at = T;
        2:       done_at = 1;
        default: done_at = $urandom_range(1, T - 1);
      endcase
      request(kind, done_at, $urandom_range(0, 3), $urandom_range(1, 6));
      show_gap($urandom_range(0, 3));
    end

    // reset during WAIT, late done after release is ignored
    request(0, 3, 2, 1);
    bus.next_pulse = 1'b1;
    m_pend = (m_pend + 1) % N_IM;
    tick();
    bus.next_pulse = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    check_reset_vals("rst_boot");
    bus.cnn_done  = 1'b1;
    bus.cnn_class = 2'd1;
    tick();
    idle_inputs();
    check_val("rst_restart", bus.cnn_start, 1);
    check_val("rst_img",     bus.cnn_img,   0);
    check_val("rst_char",    bus.char_sel,  3);
    check_val("rst_terr",    bus.timeout_err, 0);
    wait_phase(6, 1, 2);
    request(1, 9, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
